// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack controller: FSM state encoding, op codes,
// default stack bounds and the read-wait load helper.
package stack_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPushWr,
      StPopInc,
      StPopRd,
      StPopWait,
      StDone
   } state_t;

   localparam logic OpPush = 1'b0;
   localparam logic OpPop  = 1'b1;

   localparam logic [15:0] SpTopDefault    = 16'h01FF;
   localparam logic [15:0] SpBottomDefault = 16'h0100;

   // POP_RD already covers the first read-latency cycle, so the wait counter
   // only has to cover the remaining RD_LAT-1 cycles.
   function automatic logic [1:0] rd_wait_load(input int unsigned rd_lat);
      return 2'(rd_lat - 32'd1);
   endfunction

endpackage

// File: rtl/stack_rd_wait.sv
// RAM read-latency counter: loaded with RD_LAT-1, counts down while enabled,
// and flags done once it reaches zero.
module stack_rd_wait (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [1:0] load_val,
   input  logic       en,
   output logic       done
);

   logic [1:0] cnt;

   // Load on entry to the wait phase, then count down to zero and hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 2'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != 2'd0)) begin
         cnt <= cnt - 2'd1;
      end
   end

   assign done = (cnt == 2'd0);

endmodule

// File: rtl/stack_ctrl.sv
// Stack controller: sequences one PUSH or POP at a time onto the external
// stack pointer (INC/DEC strobes) and the data RAM, with a REQ/ACK handshake.
// Optional full/empty guarding is enabled by defining STACK_GUARD_EN.
module stack_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter int unsigned DW        = 16,
   parameter logic [15:0] SP_TOP    = SpTopDefault,
   parameter logic [15:0] SP_BOTTOM = SpBottomDefault,
   parameter int unsigned RD_LAT    = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req,
   input  logic          op,
   input  logic [DW-1:0] wdata,
   output logic          ack,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          sp_inc,
   output logic          sp_dec,
   input  logic [15:0]   sp_val,
   output logic [15:0]   mem_addr,
   output logic          mem_we,
   output logic          mem_re,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          ovf,
   output logic          unf
);

   localparam logic [1:0] RdLoad = rd_wait_load(RD_LAT);

`ifdef STACK_GUARD_EN
   localparam logic GuardEn = 1'b1;
`else
   localparam logic GuardEn = 1'b0;
`endif

   state_t        state_q;
   logic [DW-1:0] wdata_q;
   logic          full;
   logic          empty;
   logic          rd_load;
   logic          rd_en;
   logic          rd_done;

   // With the guard disabled these are constant 0 and the refusal paths vanish.
   assign full  = GuardEn && (sp_val == (SP_BOTTOM - 16'd1));
   assign empty = GuardEn && (sp_val == SP_TOP);

   assign rd_load = (state_q == StPopRd);
   assign rd_en   = (state_q == StPopWait);

   stack_rd_wait u_rd_wait (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (rd_load),
      .load_val (RdLoad),
      .en       (rd_en),
      .done     (rd_done)
   );

   // Main sequencer; every strobe is registered so it aligns with its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         wdata_q <= '0;
         ack     <= 1'b0;
         rdata   <= '0;
         busy    <= 1'b0;
         sp_inc  <= 1'b0;
         sp_dec  <= 1'b0;
         mem_we  <= 1'b0;
         mem_re  <= 1'b0;
         ovf     <= 1'b0;
         unf     <= 1'b0;
      end else begin
         ack    <= 1'b0;
         sp_inc <= 1'b0;
         sp_dec <= 1'b0;
         mem_we <= 1'b0;
         mem_re <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  wdata_q <= wdata;
                  busy    <= 1'b1;
                  ovf     <= 1'b0;
                  unf     <= 1'b0;
                  if (op == OpPush) begin
                     if (full) begin
                        ovf     <= 1'b1;
                        ack     <= 1'b1;
                        state_q <= StDone;
                     end else begin
                        mem_we  <= 1'b1;
                        sp_dec  <= 1'b1;
                        state_q <= StPushWr;
                     end
                  end else begin
                     if (empty) begin
                        unf     <= 1'b1;
                        ack     <= 1'b1;
                        state_q <= StDone;
                     end else begin
                        sp_inc  <= 1'b1;
                        state_q <= StPopInc;
                     end
                  end
               end
            end
            StPushWr: begin
               ack     <= 1'b1;
               state_q <= StDone;
            end
            StPopInc: begin
               mem_re  <= 1'b1;
               state_q <= StPopRd;
            end
            StPopRd: begin
               state_q <= StPopWait;
            end
            StPopWait: begin
               if (rd_done) begin
                  rdata   <= mem_rdata;
                  ack     <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDone: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Address tracks the live SP so the pop read sees the already-incremented value.
   assign mem_addr  = (mem_we || mem_re) ? sp_val : 16'h0000;
   assign mem_wdata = mem_we ? wdata_q : '0;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: two instances (RD_LAT=1 and RD_LAT=3), each with its own
// stack-pointer register and RAM, driven by directed and random push/pop ops
// and checked against a plain stack model. Honours STACK_GUARD_EN if defined.
module tb_stack_ctrl;

   localparam logic [15:0] SpTop  = 16'h01FF;
   localparam logic [15:0] SpFull = 16'h00FF;
`ifdef STACK_GUARD_EN
   localparam bit Guard = 1'b1;
`else
   localparam bit Guard = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        req = 1'b0;
   logic        op = 1'b0;
   logic [15:0] wdata = 16'h0;
   logic        sel = 1'b0;
   logic        sp_ld = 1'b0;
   logic [15:0] sp_ld_val = 16'h0;

   logic        req0, ack0, busy0, inc0, dec0, we0, re0, ovf0, unf0;
   logic [15:0] rdata0, sp0, addr0, mwd0, mrd0;
   logic        req1, ack1, busy1, inc1, dec1, we1, re1, ovf1, unf1;
   logic [15:0] rdata1, sp1, addr1, mwd1, mrd1;

   assign req0 = req && !sel;
   assign req1 = req && sel;

   stack_ctrl #(.DW(16), .SP_TOP(16'h01FF), .SP_BOTTOM(16'h0100), .RD_LAT(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req(req0), .op(op), .wdata(wdata), .ack(ack0),
      .rdata(rdata0), .busy(busy0), .sp_inc(inc0), .sp_dec(dec0), .sp_val(sp0),
      .mem_addr(addr0), .mem_we(we0), .mem_re(re0), .mem_wdata(mwd0), .mem_rdata(mrd0),
      .ovf(ovf0), .unf(unf0)
   );

   stack_ctrl #(.DW(16), .SP_TOP(16'h01FF), .SP_BOTTOM(16'h0100), .RD_LAT(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req(req1), .op(op), .wdata(wdata), .ack(ack1),
      .rdata(rdata1), .busy(busy1), .sp_inc(inc1), .sp_dec(dec1), .sp_val(sp1),
      .mem_addr(addr1), .mem_we(we1), .mem_re(re1), .mem_wdata(mwd1), .mem_rdata(mrd1),
      .ovf(ovf1), .unf(unf1)
   );

   // Stack pointer registers, as the real SP unit behaves.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp0 <= 16'h01FF;
         sp1 <= 16'h01FF;
      end else begin
         if (sp_ld && !sel) sp0 <= sp_ld_val;
         else if (inc0)     sp0 <= sp0 + 16'd1;
         else if (dec0)     sp0 <= sp0 - 16'd1;
         if (sp_ld && sel)  sp1 <= sp_ld_val;
         else if (inc1)     sp1 <= sp1 + 16'd1;
         else if (dec1)     sp1 <= sp1 - 16'd1;
      end
   end

   // RAMs: read data is valid for exactly one cycle, RD_LAT cycles after MEM_RE.
   logic [15:0] ram0 [1024] = '{default: 16'h0};
   logic [15:0] ram1 [1024] = '{default: 16'h0};
   logic [15:0] p1a, p1b, p1c;
   always @(posedge clk) begin
      if (we0) ram0[addr0[9:0]] <= mwd0;
      if (we1) ram1[addr1[9:0]] <= mwd1;
      mrd0 <= re0 ? ram0[addr0[9:0]] : 16'hDEAD;
      p1a  <= re1 ? ram1[addr1[9:0]] : 16'hDEAD;
      p1b  <= p1a;
      p1c  <= p1b;
   end
   assign mrd1 = p1c;

   logic        o_ack, o_busy, o_inc, o_dec, o_we, o_re, o_ovf, o_unf;
   logic [15:0] o_rdata, o_addr, o_mwd;
   always_comb begin
      o_ack   = sel ? ack1 : ack0;
      o_busy  = sel ? busy1 : busy0;
      o_inc   = sel ? inc1 : inc0;
      o_dec   = sel ? dec1 : dec0;
      o_we    = sel ? we1 : we0;
      o_re    = sel ? re1 : re0;
      o_ovf   = sel ? ovf1 : ovf0;
      o_unf   = sel ? unf1 : unf0;
      o_rdata = sel ? rdata1 : rdata0;
      o_addr  = sel ? addr1 : addr0;
      o_mwd   = sel ? mwd1 : mwd0;
   end

   // Reference model: per-lane SP, last pop result, and stack memory contents.
   logic [15:0] sp_m [2];
   logic [15:0] last_rd [2];
   logic [15:0] mem_m [int];
   bit          just_acked = 1'b0;
   bit          prev_lane = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_strobes"}, {24'h0, o_ack, o_busy, o_inc, o_dec, o_we, o_re, o_ovf, o_unf},
               32'h0);
      check_eq({tag, "_rdata"}, {16'h0, o_rdata}, 32'h0);
      check_eq({tag, "_addr_wdata"}, {o_addr, o_mwd}, 32'h0);
   endtask

   task automatic idle(input int n);
      req = 1'b0;
      repeat (n) @(negedge clk);
      if (n > 0) just_acked = 1'b0;
   endtask

   task automatic set_sp(input bit ln, input logic [15:0] v);
      req       = 1'b0;
      sel       = ln;
      sp_ld     = 1'b1;
      sp_ld_val = v;
      @(negedge clk);
      sp_ld      = 1'b0;
      sp_m[ln]   = v;
      just_acked = 1'b0;
   endtask

   // Issue one op from a negedge and check the whole transaction against the model.
   task automatic do_op(input bit ln, input bit o, input logic [15:0] d, input bit keep);
      int          exp_wait, w, c, lat, viol;
      int          nwe, nre, ninc, ndec;
      bit          e_we, e_re, e_inc, e_dec, e_ovf, e_unf;
      logic [15:0] sp_before, e_rd, we_addr, we_data, re_addr;
      int          rd_lat;
      rd_lat    = ln ? 3 : 1;
      exp_wait  = (just_acked && ln == prev_lane) ? 2 : 1;
      sp_before = sp_m[ln];
      {e_we, e_re, e_inc, e_dec, e_ovf, e_unf} = '0;
      e_rd = last_rd[ln];
      if (o == 1'b0) begin
         if (Guard && sp_before == SpFull) begin
            e_ovf = 1'b1;
            lat   = 1;
         end else begin
            e_we  = 1'b1;
            e_dec = 1'b1;
            lat   = 2;
            mem_m[int'(ln) * 65536 + int'(sp_before)] = d;
            sp_m[ln] = sp_before - 16'd1;
         end
      end else begin
         if (Guard && sp_before == SpTop) begin
            e_unf = 1'b1;
            lat   = 1;
         end else begin
            e_inc    = 1'b1;
            e_re     = 1'b1;
            lat      = 3 + rd_lat;
            sp_m[ln] = sp_before + 16'd1;
            if (mem_m.exists(int'(ln) * 65536 + int'(sp_m[ln])))
               e_rd = mem_m[int'(ln) * 65536 + int'(sp_m[ln])];
            else
               e_rd = 16'h0;
            last_rd[ln] = e_rd;
         end
      end

      sel   = ln;
      req   = 1'b1;
      op    = o;
      wdata = d;
      w     = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!o_busy && w < 6);
      check_eq("accept_wait", w, exp_wait);
      req   = keep;
      wdata = 16'($urandom);

      {nwe, nre, ninc, ndec, viol} = '0;
      {we_addr, we_data, re_addr} = '0;
      c = 1;
      while (c <= 12) begin
         if (!o_busy) viol++;
         if (o_we && o_re) viol++;
         if (o_inc && o_dec) viol++;
         if (!o_we && !o_re && o_addr != 16'h0) viol++;
         if (o_we) begin nwe++; we_addr = o_addr; we_data = o_mwd; end
         if (o_re) begin nre++; re_addr = o_addr; end
         if (o_inc) ninc++;
         if (o_dec) ndec++;
         if (o_ack) break;
         @(negedge clk);
         c++;
      end
      check_eq("latency", c, lat);
      check_eq("busy_excl_addr", viol, 0);
      check_eq("we_cnt", nwe, int'(e_we));
      check_eq("re_cnt", nre, int'(e_re));
      check_eq("inc_dec_cnt", {ninc[15:0], ndec[15:0]}, {15'h0, e_inc, 15'h0, e_dec});
      if (e_we) check_eq("push_addr_data", {we_addr, we_data}, {sp_before, d});
      if (e_re) check_eq("pop_addr", re_addr, sp_before + 16'd1);
      check_eq("rdata", o_rdata, e_rd);
      check_eq("ovf_unf", {o_ovf, o_unf}, {e_ovf, e_unf});
      just_acked = 1'b1;
      prev_lane  = ln;
   endtask

   initial begin
      int nack;
      bit ln, o, keep;
      sp_m[0] = SpTop;  sp_m[1] = SpTop;
      last_rd[0] = 16'h0;  last_rd[1] = 16'h0;

      // Reset state of both instances.
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      sel = 1'b0; #1 check_reset_outputs("reset_l0");
      sel = 1'b1; #1 check_reset_outputs("reset_l1");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic push then pop, RD_LAT=1.
      do_op(1'b0, 1'b0, 16'h1234, 1'b0);
      do_op(1'b0, 1'b1, 16'h0000, 1'b0);

      // REQ held through a push: next op only after the ACK cycle, one ACK each.
      do_op(1'b0, 1'b0, 16'hA5A5, 1'b1);
      do_op(1'b0, 1'b0, 16'h5A5A, 1'b0);
      nack = 0;
      repeat (4) begin
         @(negedge clk);
         if (o_ack) nack++;
      end
      check_eq("no_stray_ack", nack, 0);
      just_acked = 1'b0;
      do_op(1'b0, 1'b1, 16'h0, 1'b0);
      do_op(1'b0, 1'b1, 16'h0, 1'b0);

      // RD_LAT=3 instance.
      idle(1);
      do_op(1'b1, 1'b0, 16'hBEEF, 1'b0);
      do_op(1'b1, 1'b1, 16'h0, 1'b0);

      // Empty pop and full push; guard build refuses them, default build wraps.
      set_sp(1'b0, SpTop);
      do_op(1'b0, 1'b1, 16'h0, 1'b0);
      set_sp(1'b0, SpFull);
      do_op(1'b0, 1'b0, 16'h7777, 1'b0);
      do_op(1'b0, 1'b1, 16'h0, 1'b0);
      set_sp(1'b0, SpTop);

      // Random mix on both lanes.
      keep = 1'b0;
      for (int i = 0; i < 40; i++) begin
         ln = 1'($urandom_range(0, 1));
         o  = 1'($urandom_range(0, 1));
         if (!keep || $urandom_range(0, 1) == 0) idle($urandom_range(0, 2));
         keep = ($urandom_range(0, 3) == 0);
         do_op(ln, o, 16'($urandom), keep);
      end
      idle(2);

      // Reset in the middle of a pop: no ACK, everything cleared.
      do_op(1'b1, 1'b0, 16'hC0DE, 1'b0);
      do_op(1'b1, 1'b0, 16'h1111, 1'b0);
      do_op(1'b1, 1'b1, 16'h0, 1'b0);
      idle(1);
      sel = 1'b1;
      req = 1'b1;
      op  = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      req = 1'b0;
      #1 check_reset_outputs("midop_reset_l1");
      sel = 1'b0;
      #1 check_reset_outputs("midop_reset_l0");
      sel = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      sp_m[0] = SpTop;  sp_m[1] = SpTop;
      last_rd[0] = 16'h0;  last_rd[1] = 16'h0;
      nack = 0;
      repeat (10) begin
         @(negedge clk);
         if (o_ack) nack++;
      end
      check_eq("no_ack_after_reset", nack, 0);
      just_acked = 1'b0;
      do_op(1'b1, 1'b0, 16'hABCD, 1'b0);
      do_op(1'b1, 1'b1, 16'h0, 1'b0);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
